// File: rtl/mul_acc_ctrl.sv
// Dot-product accumulator behind a fixed-latency, non-stalling multiplier: issues are tagged through a
// valid/last delay line, matching products are summed, and one result is held on a valid/ready output.
module mul_acc_ctrl #(
   parameter int LATENCY = 5,
   parameter int PW      = 128,
   parameter int ACC_W   = 136,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic             issue_last,
   output logic             issue_ready,
   input  logic [PW-1:0]    prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   logic [LATENCY-1:0] vld_d;
   logic [LATENCY-1:0] lst_d;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;

   logic               issue_fire;
   logic               arrive;
   logic               arrive_last;
   logic               last_in_flight;
   logic [PW-1:0]      prod_m;
   logic [ACC_W:0]     sum_ext;
   logic [CNT_W-1:0]   cnt_inc;

   // A last in flight will need the result register, so new issues wait until it has landed.
   assign last_in_flight = |(vld_d & lst_d);
   assign issue_ready    = !((out_valid & !out_ready) | last_in_flight);
   assign issue_fire     = issue_valid & issue_ready;

   assign arrive      = vld_d[LATENCY-1];
   assign arrive_last = arrive & lst_d[LATENCY-1];
   assign prod_m      = arrive ? prod : '0;
   assign sum_ext     = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, prod_m};
   assign cnt_inc     = cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_d <= '0;
         lst_d <= '0;
      end else begin
         vld_d <= {vld_d[LATENCY-2:0], issue_fire};
         lst_d <= {lst_d[LATENCY-2:0], issue_fire & issue_last};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (arrive_last) begin
         // Loading a new result also covers the case where the old one is consumed on this edge.
         out_sum   <= sum_ext[ACC_W-1:0];
         out_count <= cnt_inc;
         out_ovf   <= ovf | sum_ext[ACC_W];
         out_valid <= 1'b1;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
      end else begin
         if (arrive) begin
            acc <= sum_ext[ACC_W-1:0];
            cnt <= cnt_inc;
            ovf <= ovf | sum_ext[ACC_W];
         end
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Bench for mul_acc_ctrl: a queue-based multiplier model drives products at issue+LATENCY and a
// big-integer dot-product model predicts every result.
module tb_mul_acc_ctrl;
   localparam int LATENCY = 5;
   localparam int PW      = 128;
   localparam int ACC_W   = 136;
   localparam int CNT_W   = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             issue_valid = 1'b0;
   logic             issue_last = 1'b0;
   logic             issue_ready;
   logic [PW-1:0]    prod = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_cyc = 0;

   typedef struct {
      int          due;
      logic [PW-1:0] val;
   } prod_t;

   typedef struct {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] count;
      logic             ovf;
   } res_t;

   prod_t        prod_q[$];
   res_t         exp_q[$];
   logic [159:0] mdl_total = '0;
   int           mdl_n = 0;

   mul_acc_ctrl #(.LATENCY(LATENCY), .PW(PW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
      .issue_ready(issue_ready), .prod(prod), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Multiplier model: each accepted issue's product appears exactly LATENCY cycles later, junk otherwise.
   always @(negedge clk) begin
      while (prod_q.size() > 0 && prod_q[0].due < cyc) void'(prod_q.pop_front());
      if (prod_q.size() > 0 && prod_q[0].due == cyc) begin
         prod = prod_q[0].val;
         void'(prod_q.pop_front());
      end else begin
         prod = rand128();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic model_clear();
      exp_q.delete();
      mdl_total = '0;
      mdl_n = 0;
   endtask

   task automatic issue_one(input logic [PW-1:0] v, input logic last);
      int    n;
      prod_t p;
      res_t  r;
      issue_valid = 1'b1;
      issue_last  = last;
      n = 0;
      while (!issue_ready && n < 300) begin
         tick();
         n++;
      end
      if (!issue_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: issue_ready=%0b after %0d cycles, required 1", issue_ready, n);
         issue_valid = 1'b0;
         issue_last  = 1'b0;
         return;
      end
      p.due = cyc + LATENCY;
      p.val = v;
      prod_q.push_back(p);
      mdl_total = mdl_total + 160'(v);
      mdl_n++;
      last_cyc = cyc;
      if (last) begin
         r.sum   = mdl_total[ACC_W-1:0];
         r.count = CNT_W'(mdl_n);
         r.ovf   = (mdl_total >> ACC_W) != 0;
         exp_q.push_back(r);
         mdl_total = '0;
         mdl_n = 0;
      end
      tick();
      issue_valid = 1'b0;
      issue_last  = 1'b0;
   endtask

   task automatic wait_out(output int seen, output bit ok);
      int n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      ok   = out_valid;
      seen = cyc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      model_clear();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
      n_vec++; if (out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got %h, required 0", out_sum); end
      n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL reset_out_count: got %0d, required 0", out_count); end
      n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf: got %0b, required 0", out_ovf); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_ready: got %0b, required 1", issue_ready); end
   endtask

   task automatic test_basic();
      int seen;
      bit ok;
      out_ready = 1'b1;
      issue_one(128'd5, 1'b0);
      issue_one(128'd7, 1'b0);
      issue_one(128'd11, 1'b1);
      wait_out(seen, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout: out_valid=%0b, required 1", out_valid); end
      n_vec++; if (seen !== last_cyc + LATENCY + 1) begin n_err++; $display("FAIL basic_latency: got %0d cycles, required %0d", seen - last_cyc, LATENCY + 1); end
      n_vec++; if (out_sum !== 136'd23) begin n_err++; $display("FAIL basic_sum: got %0d, required 23", out_sum); end
      n_vec++; if (out_count !== 16'd3) begin n_err++; $display("FAIL basic_count: got %0d, required 3", out_count); end
      n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %0b, required 0", out_ovf); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_consume: out_valid=%0b, required 0", out_valid); end
   endtask

   task automatic run_ones(input int n, input logic [ACC_W-1:0] want_sum, input logic want_ovf, input string tag);
      logic [PW-1:0] ones;
      int  seen;
      bit  ok;
      ones = '1;
      for (int i = 0; i < n; i++) issue_one(ones, i == n - 1);
      wait_out(seen, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL %s_timeout: out_valid=%0b, required 1", tag, out_valid); end
      n_vec++; if (out_sum !== want_sum) begin n_err++; $display("FAIL %s_sum: got %h, required %h", tag, out_sum, want_sum); end
      n_vec++; if (out_count !== CNT_W'(n)) begin n_err++; $display("FAIL %s_count: got %0d, required %0d", tag, out_count, n); end
      n_vec++; if (out_ovf !== want_ovf) begin n_err++; $display("FAIL %s_ovf: got %0b, required %0b", tag, out_ovf, want_ovf); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
   endtask

   task automatic test_overflow();
      logic [ACC_W-1:0] ones_w;
      ones_w = {8'h00, {PW{1'b1}}};
      out_ready = 1'b1;
      run_ones(1, ones_w, 1'b0, "ovf_single");
      // 256 * (2^128-1) stays just below 2^136; one more element crosses it.
      run_ones(256, ACC_W'(ones_w * 136'd256), 1'b0, "ovf_256");
      run_ones(257, ACC_W'(ones_w * 136'd257), 1'b1, "ovf_257");
   endtask

   task automatic test_backpressure();
      logic [ACC_W-1:0] snap_sum;
      logic [CNT_W-1:0] snap_cnt;
      logic             snap_ovf;
      res_t r;
      int   seen;
      bit   ok;
      bit   stable;
      bit   blocked;
      out_ready = 1'b0;
      issue_one(rand128(), 1'b0);
      issue_one(rand128(), 1'b0);
      issue_one(rand128(), 1'b1);
      n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_in_flight: got %0b, required 0", issue_ready); end
      wait_out(seen, ok);
      r = exp_q.pop_front();
      n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout: out_valid=%0b, required 1", out_valid); end
      n_vec++; if (out_sum !== r.sum || out_count !== r.count || out_ovf !== r.ovf) begin
         n_err++; $display("FAIL bp_result: got sum=%h cnt=%0d ovf=%0b, required sum=%h cnt=%0d ovf=%0b", out_sum, out_count, out_ovf, r.sum, r.count, r.ovf);
      end
      snap_sum = out_sum;
      snap_cnt = out_count;
      snap_ovf = out_ovf;
      stable  = 1'b1;
      blocked = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_sum !== snap_sum || out_count !== snap_cnt || out_ovf !== snap_ovf) stable = 1'b0;
         if (issue_ready !== 1'b0) blocked = 1'b0;
      end
      n_vec++; if (!stable) begin n_err++; $display("FAIL bp_hold: got valid=%0b sum=%h, required valid=1 sum=%h", out_valid, out_sum, snap_sum); end
      n_vec++; if (!blocked) begin n_err++; $display("FAIL bp_ready_held: got issue_ready=%0b, required 0", issue_ready); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: out_valid=%0b, required 0", out_valid); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %0b, required 1", issue_ready); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      fork
         begin
            for (int v = 0; v < 2; v++)
               for (int i = 0; i < 3; i++) issue_one(rand128(), i == 2);
         end
         begin
            for (int k = 0; k < 2; k++) begin
               int   seen;
               bit   ok;
               res_t r;
               wait_out(seen, ok);
               n_vec++;
               if (!ok || exp_q.size() == 0) begin
                  n_err++; $display("FAIL b2b_timeout_%0d: out_valid=%0b, required 1", k, out_valid);
               end else begin
                  r = exp_q.pop_front();
                  if (out_sum !== r.sum || out_count !== r.count || out_ovf !== r.ovf) begin
                     n_err++; $display("FAIL b2b_result_%0d: got sum=%h cnt=%0d, required sum=%h cnt=%0d", k, out_sum, out_count, r.sum, r.count);
                  end
               end
               tick();
            end
         end
      join
   endtask

   task automatic test_random();
      int nvec = 10;
      fork
         begin
            for (int v = 0; v < nvec; v++) begin
               int len = $urandom_range(1, 6);
               for (int i = 0; i < len; i++) begin
                  repeat ($urandom_range(0, 2)) tick();
                  issue_one(rand128(), i == len - 1);
               end
            end
         end
         begin
            int got = 0;
            int n = 0;
            while (got < nvec && n < 3000) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 2) != 0);
               #1;
               n++;
               if (out_valid && out_ready) begin
                  res_t r;
                  n_vec++;
                  if (exp_q.size() == 0) begin
                     n_err++; $display("FAIL rand_extra: unexpected result sum=%h, required none", out_sum);
                  end else begin
                     r = exp_q.pop_front();
                     if (out_sum !== r.sum || out_count !== r.count || out_ovf !== r.ovf) begin
                        n_err++; $display("FAIL rand_result_%0d: got sum=%h cnt=%0d ovf=%0b, required sum=%h cnt=%0d ovf=%0b", got, out_sum, out_count, out_ovf, r.sum, r.count, r.ovf);
                     end
                  end
                  got++;
               end
            end
            n_vec++;
            if (got != nvec) begin n_err++; $display("FAIL rand_count: got %0d results, required %0d", got, nvec); end
            out_ready = 1'b1;
         end
      join
      tick();
   endtask

   task automatic test_reset_mid();
      int seen;
      bit ok;
      bit quiet;
      out_ready = 1'b1;
      issue_one(rand128(), 1'b0);
      issue_one(rand128(), 1'b0);
      issue_one(rand128(), 1'b1);
      repeat (2) tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      model_clear();
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (out_valid !== 1'b0) quiet = 1'b0;
         tick();
      end
      n_vec++; if (!quiet) begin n_err++; $display("FAIL rstmid_quiet: out_valid=%0b seen, required 0", out_valid); end
      issue_one(128'd4, 1'b1);
      wait_out(seen, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout: out_valid=%0b, required 1", out_valid); end
      n_vec++; if (out_sum !== 136'd4) begin n_err++; $display("FAIL rstmid_sum: got %0d, required 4", out_sum); end
      n_vec++; if (out_count !== 16'd1) begin n_err++; $display("FAIL rstmid_count: got %0d, required 1", out_count); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
